sram_burst_master: RTL and testbench

Sequential initiator for the single-port 32-bit register SRAM: combinational read, write on the rising clock edge. Accepts one burst command at a time and moves a contiguous block of words. Write bursts move data from a valid/ready input stream into the SRAM. Read bursts move data from the SRAM onto a registered valid/ready output stream. It sits between the SIMD datapath/loader logic and the SRAM port, replacing ad-hoc address/write sequencing.

---
 rtl/sram_burst_master_pkg.sv | 13 +
 rtl/sram_rd_stage.sv | 58 +++++
 rtl/sram_burst_master.sv | 151 +++++++++++++++
 tb/tb_sram_burst_master.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_burst_master_pkg.sv
// Shared types and constants for the SRAM burst master.
package sram_burst_master_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/sram_rd_stage.sv
// One-entry registered read output: captures a word on load, holds it until
// the consumer takes it.
module sram_rd_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  last_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic                  free_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o
);

  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Slot can take a new word when empty or when its word leaves this cycle.
  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign data_o  = data_q;

  // Next-state for the output slot: load wins over consume.
  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      last_d  = last_i;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output slot registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/sram_burst_master.sv
// Burst initiator for a single-port SRAM with combinational read: streams
// write data into memory and memory contents out onto a registered stream.
module sram_burst_master
  import sram_burst_master_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [ADDR_WIDTH:0]   i_cmd_len,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_last,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_write,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH:0]   REM_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  done_q, done_d;
  logic                  rd_load_s;
  logic                  rd_last_s;
  logic                  rd_free_s;

  assign o_mem_addr = addr_q;
  assign o_mem_data = i_wr_data;
  assign o_busy     = (state_q != IDLE);
  assign o_done     = done_q;
  assign rd_last_s  = (rem_q == REM_ONE);

  // Burst sequencing: command acceptance, beat counting and handshakes.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    done_d      = 1'b0;
    rd_load_s   = 1'b0;
    o_cmd_ready = 1'b0;
    o_wr_ready  = 1'b0;
    o_mem_write = 1'b0;
    case (state_q)
      IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          addr_d = i_cmd_addr;
          rem_d  = i_cmd_len;
          if (i_cmd_len == REM_ZERO) begin
            done_d = 1'b1;
          end else if (i_cmd_write) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        o_wr_ready  = 1'b1;
        o_mem_write = i_wr_valid;
        if (i_wr_valid) begin
          addr_d = addr_q + ADDR_ONE;
          rem_d  = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = WRITE;
          end
        end else begin
          state_d = WRITE;
        end
      end
      READ: begin
        // Memory read is combinational, so addr_q is the word captured now.
        if ((rem_q != REM_ZERO) && rd_free_s) begin
          rd_load_s = 1'b1;
          addr_d    = addr_q + ADDR_ONE;
          rem_d     = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = DRAIN;
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = READ;
        end
      end
      DRAIN: begin
        if (o_rd_valid && i_rd_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and completion pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      rem_q   <= REM_ZERO;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  sram_rd_stage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rd_stage (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .load_i (rd_load_s),
    .last_i (rd_last_s),
    .data_i (i_mem_data),
    .ready_i(i_rd_ready),
    .free_o (rd_free_s),
    .valid_o(o_rd_valid),
    .data_o (o_rd_data),
    .last_o (o_rd_last)
  );

endmodule

// File: tb/tb_sram_burst_master.sv
// Randomized bench for sram_burst_master against an array-based memory model.
module tb_sram_burst_master;

  logic        clk;
  logic        rst_n;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_write;
  logic [7:0]  i_cmd_addr;
  logic [8:0]  i_cmd_len;
  logic        i_wr_valid;
  logic        o_wr_ready;
  logic [31:0] i_wr_data;
  logic        o_rd_valid;
  logic        i_rd_ready;
  logic [31:0] o_rd_data;
  logic        o_rd_last;
  logic [7:0]  o_mem_addr;
  logic        o_mem_write;
  logic [31:0] o_mem_data;
  logic [31:0] i_mem_data;
  logic        o_busy;
  logic        o_done;

  logic [31:0] sram    [0:255];
  logic [31:0] ref_mem [0:255];
  logic        init_en;
  int          cyc;
  int          total;
  int          bad;

  sram_burst_master #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready),
    .i_cmd_write(i_cmd_write),
    .i_cmd_addr (i_cmd_addr),
    .i_cmd_len  (i_cmd_len),
    .i_wr_valid (i_wr_valid),
    .o_wr_ready (o_wr_ready),
    .i_wr_data  (i_wr_data),
    .o_rd_valid (o_rd_valid),
    .i_rd_ready (i_rd_ready),
    .o_rd_data  (o_rd_data),
    .o_rd_last  (o_rd_last),
    .o_mem_addr (o_mem_addr),
    .o_mem_write(o_mem_write),
    .o_mem_data (o_mem_data),
    .i_mem_data (i_mem_data),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // SRAM: combinational read, write on rising edge.
  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 256; i++) sram[i] <= init_word(i);
    end else if (o_mem_write) begin
      sram[o_mem_addr] <= o_mem_data;
    end
  end
  assign i_mem_data = sram[o_mem_addr];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd_noise();
    i_cmd_valid = 1'($urandom_range(0, 1));
    i_cmd_write = 1'($urandom_range(0, 1));
    i_cmd_addr  = 8'($urandom);
    i_cmd_len   = 9'($urandom);
  endtask

  task automatic mem_cmp(input string tag);
    for (int i = 0; i < 256; i++)
      chk($sformatf("%s[%0d]", tag, i), sram[i], ref_mem[i]);
  endtask

  task automatic do_write(input logic [7:0] a, input int n, input bit directed);
    logic [31:0] d [$];
    int beats;
    int t0;
    int wd;
    beats = 0;
    wd    = 0;
    for (int i = 0; i < n; i++) d.push_back(directed ? 32'hA0 + 32'(i) : $urandom);
    chk("w_cmd_ready", o_cmd_ready, 1);
    i_cmd_valid = 1'b1;
    i_cmd_write = 1'b1;
    i_cmd_addr  = a;
    i_cmd_len   = 9'(n);
    t0 = cyc;
    tick();
    chk("w_busy", o_busy, 1);
    while (beats < n && wd < 4000) begin
      cmd_noise();
      i_wr_valid = directed ? 1'b1 : 1'($urandom_range(0, 1));
      i_wr_data  = d[beats];
      #1;
      chk("w_addr", o_mem_addr, 8'(a + beats));
      chk("w_we", o_mem_write, i_wr_valid);
      chk("w_ready", o_wr_ready, 1);
      if (i_wr_valid) begin
        ref_mem[8'(a + beats)] = d[beats];
        beats++;
      end
      tick();
      wd++;
    end
    if (wd >= 4000) chk("w_timeout", 1, 0);
    i_wr_valid  = 1'b0;
    i_cmd_valid = 1'b0;
    #1;
    chk("w_done", o_done, 1);
    chk("w_idle", o_busy, 0);
    chk("w_cmd_ready_back", o_cmd_ready, 1);
    if (directed) chk("w_done_lat", 64'(cyc - t0), 64'(n + 1));
  endtask

  task automatic do_read(input logic [7:0] a, input int n, input int mode);
    int k;
    int t0;
    int wd;
    int t_first;
    int step;
    logic [31:0] hold_d;
    logic hold;
    logic rdy;
    k = 0;
    wd = 0;
    t_first = -1;
    step = 0;
    hold = 1'b0;
    hold_d = 32'h0;
    chk("r_cmd_ready", o_cmd_ready, 1);
    i_cmd_valid = 1'b1;
    i_cmd_write = 1'b0;
    i_cmd_addr  = a;
    i_cmd_len   = 9'(n);
    t0 = cyc;
    tick();
    chk("r_busy", o_busy, 1);
    while (k < n && wd < 4000) begin
      cmd_noise();
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = (step % 3 == 0);
      else rdy = 1'($urandom_range(0, 1));
      i_rd_ready = rdy;
      #1;
      chk("r_we", o_mem_write, 0);
      if (hold) begin
        chk("r_hold_valid", o_rd_valid, 1);
        chk("r_hold_data", o_rd_data, hold_d);
      end
      if (o_rd_valid) begin
        if (t_first < 0) t_first = cyc;
        if (rdy) begin
          chk("r_data", o_rd_data, ref_mem[8'(a + k)]);
          chk("r_last", o_rd_last, (k == n - 1));
          k++;
          hold = 1'b0;
        end else begin
          hold   = 1'b1;
          hold_d = o_rd_data;
        end
      end else begin
        hold = 1'b0;
      end
      step++;
      tick();
      wd++;
    end
    if (wd >= 4000) chk("r_timeout", 1, 0);
    i_rd_ready  = 1'b0;
    i_cmd_valid = 1'b0;
    #1;
    chk("r_done", o_done, 1);
    chk("r_idle", o_busy, 0);
    chk("r_valid_clear", o_rd_valid, 0);
    if (mode == 0) begin
      chk("r_first_lat", 64'(t_first - t0), 2);
      chk("r_done_lat", 64'(cyc - t0), 64'(n + 2));
    end
  endtask

  task automatic do_len0();
    chk("z_cmd_ready", o_cmd_ready, 1);
    i_cmd_valid = 1'b1;
    i_cmd_write = 1'b1;
    i_cmd_addr  = 8'h44;
    i_cmd_len   = 9'd0;
    i_wr_valid  = 1'b1;
    #1;
    chk("z_we_cmd", o_mem_write, 0);
    tick();
    i_cmd_valid = 1'b0;
    #1;
    chk("z_busy", o_busy, 0);
    chk("z_done", o_done, 1);
    chk("z_we", o_mem_write, 0);
    tick();
    chk("z_done_once", o_done, 0);
    chk("z_we2", o_mem_write, 0);
    i_wr_valid = 1'b0;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    cyc         = 0;
    rst_n       = 1'b0;
    init_en     = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_write = 1'b0;
    i_cmd_addr  = 8'h0;
    i_cmd_len   = 9'h0;
    i_wr_valid  = 1'b0;
    i_wr_data   = 32'h0;
    i_rd_ready  = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    tick();
    tick();
    init_en = 1'b0;
    chk("rst_cmd_ready", o_cmd_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_rd_valid", o_rd_valid, 0);
    chk("rst_rd_last", o_rd_last, 0);
    chk("rst_rd_data", o_rd_data, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_mem_write", o_mem_write, 0);
    rst_n = 1'b1;
    tick();

    do_write(8'h10, 4, 1'b1);
    for (int i = 0; i < 4; i++) chk("dir_word", sram[8'h10 + i], 32'hA0 + 32'(i));
    do_read(8'h10, 4, 0);
    do_read(8'h10, 3, 1);
    do_write(8'hFE, 4, 1'b0);
    mem_cmp("wrap");
    do_len0();
    do_read(8'h37, 256, 2);
    do_read(8'h00, 256, 0);

    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1) do_write(8'($urandom), $urandom_range(1, 40), 1'b0);
      else do_read(8'($urandom), $urandom_range(1, 40), $urandom_range(0, 2));
    end
    mem_cmp("rand");

    // Abandon a write burst after three beats.
    chk("x_cmd_ready", o_cmd_ready, 1);
    i_cmd_valid = 1'b1;
    i_cmd_write = 1'b1;
    i_cmd_addr  = 8'h80;
    i_cmd_len   = 9'd8;
    tick();
    i_cmd_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      i_wr_valid = 1'b1;
      i_wr_data  = $urandom;
      ref_mem[8'(8'h80 + b)] = i_wr_data;
      tick();
    end
    i_wr_data  = 32'hDEAD_BEEF;
    i_wr_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("x_busy", o_busy, 0);
    chk("x_cmd_ready", o_cmd_ready, 1);
    chk("x_mem_write", o_mem_write, 0);
    chk("x_mem_addr", o_mem_addr, 0);
    chk("x_done", o_done, 0);
    chk("x_rd_valid", o_rd_valid, 0);
    chk("x_rd_last", o_rd_last, 0);
    chk("x_rd_data", o_rd_data, 0);
    tick();
    i_wr_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("x_no_done", o_done, 0);
    do_read(8'h80, 8, 0);
    mem_cmp("rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
